// File: rtl/mmio_input_port_if.sv
// mmio_input_port_if
// Processor data-memory bus between a CPU (master) and the MMIO input port (slave).
//   addr     : data-memory address
//   mem_rd   : single-cycle read strobe
//   mem_wr   : single-cycle write strobe
//   data_in  : processor write data
//   data_out : read data, valid only while ack is high
//   ack      : one-cycle acknowledge, one cycle after an accepted strobe
interface mmio_input_port_if;
    logic [7:0]  addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        ack;

    modport master (
        output addr,
        output mem_rd,
        output mem_wr,
        output data_in,
        input  data_out,
        input  ack
    );

    modport slave (
        input  addr,
        input  mem_rd,
        input  mem_wr,
        input  data_in,
        output data_out,
        output ack
    );
endinterface

// File: rtl/mmio_input_port.sv
// mmio_input_port
// Memory-mapped input peripheral: a debounced pushbutton, four slide switches,
// an LED register and a level interrupt, behind a 4-word register window.
//
// Register window (word offsets from BASE_ADDR):
//   +0 SWREG  RO  {12'b0, synchronized switches}
//   +1 STATUS RO  bit0 PBEV (debounced press), bit1 SWEV (switch change); read clears
//   +2 LEDREG RW  low 8 bits drive o_leds
//   +3 CTRL   RW  bit0 IE (interrupt enable)
//
// Ports:
//   i_clk   : system clock, all state on the rising edge
//   i_rst   : synchronous active-high reset
//   i_pb1   : raw pushbutton, active-low, asynchronous
//   i_sw    : raw slide switches, asynchronous
//   bus     : processor bus (slave side), registered ack/data_out
//   o_leds  : LED register contents
//   o_irq   : registered IE & (PBEV | SWEV)
module mmio_input_port #(
    parameter int unsigned DEB_CYCLES = 4,       // 1..255
    parameter logic [7:0]  BASE_ADDR  = 8'hF0    // low two bits must be zero
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pb1,
    input  logic [3:0]              i_sw,
    mmio_input_port_if.slave        bus,
    output logic [7:0]              o_leds,
    output logic                    o_irq
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned SW_W   = 4;
    localparam int unsigned LED_W  = 8;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [1:0] OFF_SW     = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_LED    = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } deb_state_t;

    // Synchronizers and switch history
    logic             r_pb_meta;
    logic             r_pb_s;
    logic [SW_W-1:0]  r_sw_meta;
    logic [SW_W-1:0]  r_sw_s;
    logic [SW_W-1:0]  r_sw_prev;

    // Debounce
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    // Registers and bus outputs
    logic             r_pbev;
    logic             r_swev;
    logic             r_ie;
    logic [LED_W-1:0] r_led;
    logic             r_irq;
    logic             r_ack;
    logic [DATA_W-1:0] r_dout;

    // Decode
    logic              w_in_win;
    logic [1:0]        w_off;
    logic              w_wr;
    logic              w_rd;
    logic              w_clr_status;
    logic [DATA_W-1:0] w_rd_data;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_press_done;
    logic              w_sw_chg;
    logic              w_unused_data;

    // Window decode; a simultaneous read+write is handled purely as a write
    assign w_in_win     = (bus.addr[7:2] == BASE_ADDR[7:2]);
    assign w_off        = bus.addr[1:0];
    assign w_wr         = bus.mem_wr & w_in_win;
    assign w_rd         = bus.mem_rd & ~bus.mem_wr & w_in_win;
    assign w_clr_status = w_rd & (w_off == OFF_STATUS);

    // Only the low byte and bit0 of write data are architecturally used
    assign w_unused_data = ^{bus.data_in[DATA_W-1:LED_W]};

    // Read mux, values as seen in the strobe cycle
    always_comb begin
        w_rd_data = '0;
        case (w_off)
            OFF_SW:     w_rd_data = DATA_W'(r_sw_s);
            OFF_STATUS: w_rd_data = DATA_W'({r_swev, r_pbev});
            OFF_LED:    w_rd_data = DATA_W'(r_led);
            OFF_CTRL:   w_rd_data = DATA_W'(r_ie);
            default:    w_rd_data = '0;
        endcase
    end

    // Saturating increment so a long DEB_CYCLES can never wrap the counter
    assign w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_press_done = (r_state == ST_PRESS_WAIT) & ~r_pb_s & (r_cnt == DEB_LAST);
    assign w_sw_chg     = (r_sw_s != r_sw_prev);

    // Two-flop synchronizers; pushbutton idles released (1)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pb_meta <= 1'b1;
            r_pb_s    <= 1'b1;
            r_sw_meta <= '0;
            r_sw_s    <= '0;
            r_sw_prev <= '0;
        end else begin
            r_pb_meta <= i_pb1;
            r_pb_s    <= r_pb_meta;
            r_sw_meta <= i_sw;
            r_sw_s    <= r_sw_meta;
            r_sw_prev <= r_sw_s;
        end
    end

    // Debounce FSM: a level change is accepted after DEB_CYCLES stable samples in a WAIT state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_pb_s) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (r_pb_s) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (r_pb_s) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!r_pb_s) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Event flags: a set in the same cycle as a STATUS read wins over the clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pbev <= 1'b0;
            r_swev <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_pbev <= w_press_done | (r_pbev & ~w_clr_status);
            r_swev <= w_sw_chg     | (r_swev & ~w_clr_status);
            r_irq  <= r_ie & (r_pbev | r_swev);
        end
    end

    // Writable registers and registered bus response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_led  <= '0;
            r_ie   <= 1'b0;
            r_ack  <= 1'b0;
            r_dout <= '0;
        end else begin
            if (w_wr && (w_off == OFF_LED)) begin
                r_led <= bus.data_in[LED_W-1:0];
            end
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_ie <= bus.data_in[0];
            end
            r_ack  <= w_rd | w_wr;
            r_dout <= w_rd ? w_rd_data : '0;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.data_out = r_dout;
    assign o_leds       = r_led;
    assign o_irq        = r_irq;

endmodule

// File: tb/tb_mmio_input_port.sv
// Testbench for mmio_input_port: directed scenarios plus randomized traffic
// checked against a behavioural model (run-length debounce, event flags, registers).
module tb_mmio_input_port;

    localparam int unsigned DEB  = 4;
    localparam logic [7:0]  BASE = 8'hF0;

    logic       clk = 1'b0;
    logic       rst;
    logic       pb1;
    logic [3:0] sw;
    logic [7:0] leds;
    logic       irq;

    int checks = 0;
    int errors = 0;

    mmio_input_port_if bus();

    mmio_input_port #(
        .DEB_CYCLES (DEB),
        .BASE_ADDR  (BASE)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pb1  (pb1),
        .i_sw   (sw),
        .bus    (bus),
        .o_leds (leds),
        .o_irq  (irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [1:0]  m_pbq;      // [0] first stage, [1] synchronized
    logic [3:0]  m_sw1, m_sw2, m_swp;
    logic        m_level;    // debounced button level, 1 = released
    int          m_run;      // consecutive synchronized samples disagreeing with m_level
    logic        m_pbev, m_swev, m_ie, m_irq, m_ack;
    logic [7:0]  m_led;
    logic [15:0] m_dout;

    logic        t_win, t_wr, t_rd, t_clr, t_press;
    int          t_off, t_run;
    logic [15:0] t_val;

    always @(posedge clk) begin
        if (rst) begin
            m_pbq <= 2'b11; m_sw1 <= 4'h0; m_sw2 <= 4'h0; m_swp <= 4'h0;
            m_level <= 1'b1; m_run <= 0;
            m_pbev <= 1'b0; m_swev <= 1'b0; m_ie <= 1'b0; m_irq <= 1'b0;
            m_ack <= 1'b0; m_led <= 8'h00; m_dout <= 16'h0000;
        end else begin
            t_off = int'(bus.addr) - int'(BASE);
            t_win = (t_off >= 0) && (t_off <= 3);
            t_wr  = t_win && bus.mem_wr;
            t_rd  = t_win && bus.mem_rd && !bus.mem_wr;
            case (t_off)
                0:       t_val = {12'h000, m_sw2};
                1:       t_val = {14'h0000, m_swev, m_pbev};
                2:       t_val = {8'h00, m_led};
                default: t_val = {15'h0000, m_ie};
            endcase
            // Level flips after DEB+1 disagreeing samples (entry sample plus DEB stable ones)
            t_press = 1'b0;
            t_run   = 0;
            if (m_pbq[1] != m_level) begin
                t_run = m_run + 1;
                if (t_run == int'(DEB) + 1) begin
                    t_run   = 0;
                    t_press = (m_pbq[1] == 1'b0);
                    m_level <= m_pbq[1];
                end
            end
            m_run <= t_run;
            m_pbq <= {m_pbq[0], pb1};
            m_sw1 <= sw; m_sw2 <= m_sw1; m_swp <= m_sw2;
            t_clr = t_rd && (t_off == 1);
            m_pbev <= t_press || (m_pbev && !t_clr);
            m_swev <= (m_sw2 != m_swp) || (m_swev && !t_clr);
            if (t_wr && t_off == 2) m_led <= bus.data_in[7:0];
            if (t_wr && t_off == 3) m_ie <= bus.data_in[0];
            m_irq  <= m_ie && (m_pbev || m_swev);
            m_ack  <= t_wr || t_rd;
            m_dout <= t_rd ? t_val : 16'h0000;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Strobe for one cycle; returns in the following cycle where ack/data are observable
    task automatic bus_op(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
        bus.addr = a; bus.mem_rd = rd; bus.mem_wr = wr; bus.data_in = d;
        cyc();
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; pb1 = 1'b1; sw = 4'h0;
        bus.addr = 8'h00; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.data_in = 16'h0000;
        repeat (4) cyc();
        bus.mem_rd = 1'b1; bus.addr = BASE + 8'd1;   // strobe during the last reset cycle
        cyc();
        rst = 1'b0; bus.mem_rd = 1'b0;
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_dropped_ack got %b want 0", bus.ack); end
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h want 0000", bus.data_out); end
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds got %h want 00", leds); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL reset_status_ack got %b want 1", bus.ack); end
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL reset_status_data got %h want 0000", bus.data_out); end
    endtask

    task automatic test_led_rw();
        bus_op(1'b0, 1'b1, BASE + 8'd2, 16'h00A5);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL led_wr_ack got %b want 1", bus.ack); end
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL led_wr_dout got %h want 0000", bus.data_out); end
        checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL led_value got %h want a5", leds); end
        cyc();
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL led_ack_single got %b want 0", bus.ack); end
        bus_op(1'b1, 1'b0, BASE + 8'd2, 16'h0000);
        checks++; if (bus.ack !== 1'b1 || bus.data_out !== 16'h00A5) begin errors++; $display("FAIL led_rd got ack %b data %h want 1 00a5", bus.ack, bus.data_out); end
        bus_op(1'b1, 1'b1, BASE + 8'd2, 16'h775A);
        checks++; if (bus.ack !== 1'b1 || bus.data_out !== 16'h0000 || leds !== 8'h5A) begin
            errors++; $display("FAIL rdwr_as_write got ack %b data %h leds %h want 1 0000 5a", bus.ack, bus.data_out, leds); end
        bus_op(1'b0, 1'b1, BASE + 8'd0, 16'hFFFF);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL swreg_wr_ack got %b want 1", bus.ack); end
        bus_op(1'b0, 1'b1, BASE + 8'd1, 16'h0003);
        bus_op(1'b1, 1'b0, BASE + 8'd0, 16'h0000);
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL swreg_ro got %h want 0000", bus.data_out); end
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL status_ro got %h want 0000", bus.data_out); end
    endtask

    task automatic test_pb_debounce();
        pb1 = 1'b0; repeat (3) cyc();
        pb1 = 1'b1; repeat (10) cyc();
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL pb_short_glitch got %h want 0000", bus.data_out); end
        pb1 = 1'b0; repeat (10) cyc();
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0001) begin errors++; $display("FAIL pb_long_press got %h want 0001", bus.data_out); end
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL pb_once got %h want 0000", bus.data_out); end
        pb1 = 1'b1; repeat (12) cyc();
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL pb_release_no_event got %h want 0000", bus.data_out); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pb_irq_disabled got %b want 0", irq); end
    endtask

    task automatic test_sw_irq();
        bus_op(1'b0, 1'b1, BASE + 8'd3, 16'h0001);
        sw = 4'hF;
        repeat (4) cyc();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sw_irq_set got %b want 1", irq); end
        bus_op(1'b1, 1'b0, BASE + 8'd0, 16'h0000);
        checks++; if (bus.data_out !== 16'h000F) begin errors++; $display("FAIL swreg_read got %h want 000f", bus.data_out); end
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0002) begin errors++; $display("FAIL swev_read got %h want 0002", bus.data_out); end
        cyc();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sw_irq_clear got %b want 0", irq); end
        bus_op(1'b1, 1'b0, BASE + 8'd3, 16'h0000);
        checks++; if (bus.data_out !== 16'h0001) begin errors++; $display("FAIL ctrl_read got %h want 0001", bus.data_out); end
    endtask

    // Press completes (PBEV set) in exactly the cycle STATUS is read; SWEV keeps IRQ high throughout
    task automatic test_status_race();
        sw = 4'h3; pb1 = 1'b0;        // cycle A
        repeat (6) cyc();             // now in cycle A+6, where the press completes
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0002) begin errors++; $display("FAIL race_sampled got %h want 0002", bus.data_out); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq_a got %b want 1", irq); end
        cyc();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq_b got %b want 1", irq); end
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0001) begin errors++; $display("FAIL race_pbev_kept got %h want 0001", bus.data_out); end
        pb1 = 1'b1; repeat (12) cyc();
    endtask

    task automatic test_out_of_window();
        logic [7:0] addrs [3];
        addrs[0] = 8'h10; addrs[1] = 8'hF4; addrs[2] = 8'hEF;
        for (int i = 0; i < 3; i++) begin
            bus_op(1'b1, 1'b0, addrs[i], 16'h0000);
            checks++; if (bus.ack !== 1'b0 || bus.data_out !== 16'h0000) begin
                errors++; $display("FAIL oow_read %h got ack %b data %h want 0 0000", addrs[i], bus.ack, bus.data_out); end
            bus_op(1'b0, 1'b1, addrs[i], 16'h00FF);
            checks++; if (bus.ack !== 1'b0 || leds !== 8'h5A) begin
                errors++; $display("FAIL oow_write %h got ack %b leds %h want 0 5a", addrs[i], bus.ack, leds); end
        end
    endtask

    task automatic test_back_to_back();
        logic        rd [6];
        logic [7:0]  ad [6];
        logic [15:0] wd [6];
        logic [15:0] ex [6];
        rd[0] = 1'b0; ad[0] = BASE + 8'd2; wd[0] = 16'h0033; ex[0] = 16'h0000;
        rd[1] = 1'b1; ad[1] = BASE + 8'd2; wd[1] = 16'h0000; ex[1] = 16'h0033;
        rd[2] = 1'b0; ad[2] = BASE + 8'd3; wd[2] = 16'h0000; ex[2] = 16'h0000;
        rd[3] = 1'b1; ad[3] = BASE + 8'd3; wd[3] = 16'h0000; ex[3] = 16'h0000;
        rd[4] = 1'b1; ad[4] = BASE + 8'd0; wd[4] = 16'h0000; ex[4] = 16'h0003;
        rd[5] = 1'b1; ad[5] = BASE + 8'd2; wd[5] = 16'h0000; ex[5] = 16'h0033;
        for (int i = 0; i < 6; i++) begin
            bus.addr = ad[i]; bus.mem_rd = rd[i]; bus.mem_wr = ~rd[i]; bus.data_in = wd[i];
            cyc();
            checks++; if (bus.ack !== 1'b1 || bus.data_out !== ex[i]) begin
                errors++; $display("FAIL b2b_%0d got ack %b data %h want 1 %h", i, bus.ack, bus.data_out, ex[i]); end
        end
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        cyc();
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL b2b_tail got ack %b want 0", bus.ack); end
    endtask

    task automatic test_reset_mid_press();
        sw = 4'h0; repeat (4) cyc();
        pb1 = 1'b0; repeat (4) cyc();
        rst = 1'b1; pb1 = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (10) cyc();
        bus_op(1'b1, 1'b0, BASE + 8'd1, 16'h0000);
        checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL midpress_pbev got %h want 0000", bus.data_out); end
        checks++; if (leds !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL midpress_regs got leds %h irq %b want 00 0", leds, irq); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) pb1 = ~pb1;
            if ($urandom_range(0, 19) == 0) sw = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 1) == 0) begin
                bus.addr    = 8'hEE + 8'($urandom_range(0, 7));
                bus.mem_rd  = 1'($urandom_range(0, 1));
                bus.mem_wr  = 1'($urandom_range(0, 1));
                bus.data_in = 16'($urandom);
            end else begin
                bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
            end
            cyc();
            checks++; if (bus.ack !== m_ack) begin errors++; $display("FAIL rnd_ack cyc %0d got %b want %b", n, bus.ack, m_ack); end
            checks++; if (bus.data_out !== m_dout) begin errors++; $display("FAIL rnd_dout cyc %0d got %h want %h", n, bus.data_out, m_dout); end
            checks++; if (leds !== m_led) begin errors++; $display("FAIL rnd_leds cyc %0d got %h want %h", n, leds, m_led); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq cyc %0d got %b want %b", n, irq, m_irq); end
        end
        rst = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_led_rw();
        test_pb_debounce();
        test_sw_irq();
        test_status_race();
        test_out_of_window();
        test_back_to_back();
        test_reset_mid_press();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_input_port.md
MMIO_INPUT_PORT -- requirements
Module: mmio_input_port

Interface
REQ-001 Parameter DEB_CYCLES, 4, number of consecutive stable synchronized samples needed to accept a PB1 level change (range 1..255).
REQ-002 Parameter BASE_ADDR, 8'hF0, base of the 4-word register window; BASE_ADDR[1:0] shall be 2'b00.
REQ-003 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 PB1  input  1  raw pushbutton, active-low (1 = released), asynchronous to Clock.
REQ-006 SW  input  4  raw slide switches, asynchronous to Clock.
REQ-007 Addr  input  8  processor data-memory address.
REQ-008 MemRd  input  1  single-cycle read strobe.
REQ-009 MemWr  input  1  single-cycle write strobe.
REQ-010 DataIn  input  16  processor write data.
REQ-011 DataOut  output  16  read data; valid only while Ack=1.
REQ-012 Ack  output  1  one-cycle acknowledge for an accepted access.
REQ-013 LEDs  output  8  LED register contents.
REQ-014 IRQ  output  1  level interrupt request.

Function
REQ-015 The block shall respond only to Addr in BASE_ADDR..BASE_ADDR+3; all other addresses produce no Ack, DataOut=0, and no state change.
REQ-016 Register map: +0 SWREG (RO, {12'b0, SW_s}); +1 STATUS (RO, bit0 PBEV, bit1 SWEV, others 0); +2 LEDREG (RW, low 8 bits); +3 CTRL (RW, bit0 IE, others read 0).
REQ-017 Access latency: strobe with in-window Addr in cycle N -> Ack=1 and DataOut valid in cycle N+1 only; DataOut=0 whenever Ack=0.
REQ-018 Write data shall be committed at the end of cycle N; writes to SWREG/STATUS shall be acknowledged and ignored.
REQ-019 MemRd and MemWr together in-window: treated as a write only, one Ack, DataOut=0.
REQ-020 Back-to-back strobes on consecutive cycles shall each be acknowledged one cycle later, no drops.
REQ-021 PB1 and SW shall each pass through a 2-flop synchronizer; SW_s is the second-stage value.
REQ-022 Debounce FSM on synchronized PB1 (pb_s): states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-023 IDLE: pb_s=0 -> PRESS_WAIT, counter cleared.
REQ-024 PRESS_WAIT: pb_s=0 for DEB_CYCLES consecutive cycles -> PRESSED; any pb_s=1 -> IDLE.
REQ-025 PRESSED: pb_s=1 -> RELEASE_WAIT, counter cleared.
REQ-026 RELEASE_WAIT: pb_s=1 for DEB_CYCLES consecutive cycles -> IDLE; any pb_s=0 -> PRESSED.
REQ-027 Transition PRESS_WAIT->PRESSED shall set PBEV (one event per debounced press; release sets nothing).
REQ-028 Any cycle where SW_s differs from its previous-cycle value shall set SWEV.
REQ-029 Reading STATUS clears PBEV and SWEV at end of cycle N; DataOut in N+1 shows values sampled in cycle N.
REQ-030 Set and clear in the same cycle: set wins; the bit remains 1 after the read.
REQ-031 IRQ = IE & (PBEV | SWEV), registered, asserted the cycle after the condition holds.
REQ-032 Debounce counter shall saturate and never wrap.

Reset
REQ-033 Reset=1 at a rising edge: FSM=IDLE, counter=0, PBEV=SWEV=0, LEDREG=0, IE=0, Ack=0, DataOut=0, IRQ=0, synchronizer flops=1 (PB1) and 0 (SW), previous SW_s=0.
REQ-034 Reset shall take precedence over any concurrent strobe; a strobe in the reset cycle is dropped (no Ack afterward).
REQ-035 SWEV shall not be set by the first post-reset SW_s update if SW_s equals 0.

Verification
REQ-036 Reset 5 cycles, PB1=1, SW=0 -> LEDs=0, IRQ=0, Ack=0; read +1 returns 16'h0000.
REQ-037 Write 16'h00A5 to +2, read +2 -> Ack one cycle after each strobe, LEDs=8'hA5, DataOut=16'h00A5.
REQ-038 PB1 low 3 cycles then high (DEB_CYCLES=4) -> PBEV stays 0; PB1 low 10 cycles -> PBEV=1 exactly once.
REQ-039 SW 0000->1111, IE=1 -> SWREG reads 16'h000F after sync, SWEV=1, IRQ=1; read +1 returns 16'h0002, then IRQ=0.
REQ-040 New PB press completes in the same cycle STATUS is read -> read data bit0 per sampled value, PBEV=1 afterward, IRQ stays 1.
REQ-041 Read Addr 8'h10 and 8'hF4 -> no Ack, DataOut=0; Reset asserted mid-press -> FSM IDLE, PBEV=0.
